// File: rtl/core_sequencer_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: state encoding, address
// select codes, the opcode set used by both decoder and sequencer, and opcode classification.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_WB     = 2'd2,
        CLS_OTHER  = 2'd3
    } op_class_t;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic op_class_t classify_op(input logic [6:0] op_i);
        op_class_t cls;
        case (op_i)
            OP_LOAD, OP_STORE:                                   cls = CLS_MEM;
            OP_BRANCH:                                           cls = CLS_BRANCH;
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:   cls = CLS_WB;
            default:                                             cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. The trap flag exists only when
// ILLEGAL_TRAP_EN is defined.
interface core_sequencer_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           op;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 mem_we;
    logic                 addr_sel;
    logic                 ir_we;
    logic                 reg_we;
    logic                 pc_we;
    logic                 retire;
    logic [INSTRET_W-1:0] instret;
    logic                 bus_error;
`ifdef ILLEGAL_TRAP_EN
    logic                 trap;

    modport master (
        input  op, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, retire,
               instret, bus_error, trap
    );
    modport slave (
        output op, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, retire,
               instret, bus_error, trap
    );
`else
    modport master (
        input  op, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, retire,
               instret, bus_error
    );
    modport slave (
        output op, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, reg_we, pc_we, retire,
               instret, bus_error
    );
`endif
endinterface

// File: rtl/core_sequencer_mem_watchdog.sv
// Memory wait watchdog: counts stalled request cycles and flags the cycle in
// which the count would reach MEM_TIMEOUT (0 disables it).
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then increment while stalled, saturating at the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable_i && (count_q != CNT_W'(MEM_TIMEOUT))) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            assign expired_o = enable_i && (count_q == CNT_W'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: write enables, memory handshake,
// retired-instruction counter and watchdog. Optional macro: ILLEGAL_TRAP_EN.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input logic              clk,
    input logic              rst_n,
    core_sequencer_if.master bus
);

    seq_state_t           state_q;
    seq_state_t           state_d;
    op_class_t            op_class_s;
    logic                 is_store_s;
    logic                 req_state_s;
    logic                 wd_clear_s;
    logic                 wd_enable_s;
    logic                 wd_expired_s;
    logic                 mem_req_s;
    logic                 mem_we_s;
    logic                 addr_sel_s;
    logic                 ir_we_s;
    logic                 reg_we_s;
    logic                 pc_we_s;
    logic                 retire_s;
    logic [INSTRET_W-1:0] instret_q;
    logic                 bus_error_q;
`ifdef ILLEGAL_TRAP_EN
    logic                 trap_set_s;
    logic                 trap_q;
`endif

    assign op_class_s  = classify_op(bus.op);
    assign is_store_s  = (bus.op == OP_STORE);
    assign req_state_s = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // Clearing on every completed request leaves the count at zero whenever FETCH or MEM is entered.
    assign wd_clear_s  = !req_state_s || bus.mem_ready;
    assign wd_enable_s = req_state_s && !bus.mem_ready;

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear_s),
        .enable_i  (wd_enable_s),
        .expired_o (wd_expired_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = ADDR_PC;
        ir_we_s    = 1'b0;
        reg_we_s   = 1'b0;
        pc_we_s    = 1'b0;
        retire_s   = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap_set_s = 1'b0;
`endif
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                addr_sel_s = ADDR_PC;
                ir_we_s    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wd_expired_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (op_class_s)
                    CLS_MEM: state_d = ST_MEM;
                    CLS_WB:  state_d = ST_WRITEBACK;
                    CLS_BRANCH: begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        trap_set_s = 1'b1;
                        state_d    = ST_HALT;
`else
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = ADDR_ALU;
                mem_we_s   = is_store_s;
                if (bus.mem_ready) begin
                    if (is_store_s) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wd_expired_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WRITEBACK: begin
                reg_we_s = 1'b1;
                pc_we_s  = 1'b1;
                retire_s = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Retired-instruction counter and sticky watchdog flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q   <= {INSTRET_W{1'b0}};
            bus_error_q <= 1'b0;
        end else begin
            if (retire_s) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
            if (wd_expired_s) begin
                bus_error_q <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (trap_set_s) begin
            trap_q <= 1'b1;
        end
    end

    assign bus.trap = trap_q;
`endif

    assign bus.mem_req   = mem_req_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.addr_sel  = addr_sel_s;
    assign bus.ir_we     = ir_we_s;
    assign bus.reg_we    = reg_we_s;
    assign bus.pc_we     = pc_we_s;
    assign bus.retire    = retire_s;
    assign bus.instret   = instret_q;
    assign bus.bus_error = bus_error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: expected per-cycle strobe traces are
// generated from the instruction-level rules and compared cycle by cycle.
module tb_core_sequencer;

    localparam int TIMEOUT = 4;
    localparam int IW      = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // strobe vector bits: {mem_req, mem_we, addr_sel(ALU, only with req), ir_we, reg_we, pc_we, retire}
    localparam logic [6:0] S_REQ = 7'b1000000;
    localparam logic [6:0] S_WE  = 7'b0100000;
    localparam logic [6:0] S_ALU = 7'b0010000;
    localparam logic [6:0] S_IR  = 7'b0001000;
    localparam logic [6:0] S_REG = 7'b0000100;
    localparam logic [6:0] S_PC  = 7'b0000010;
    localparam logic [6:0] S_RET = 7'b0000001;

    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
        logic [6:0] strobes;
    } cyc_t;

    logic clk;
    logic rst_n;
    cyc_t exp_q[$];
    int   checks;
    int   failures;
    int   instret_model;

    core_sequencer_if #(.INSTRET_W(IW)) bus ();

    core_sequencer #(
        .MEM_TIMEOUT (TIMEOUT),
        .INSTRET_W   (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.mem_req, bus.mem_we, bus.mem_req & bus.addr_sel,
                bus.ir_we, bus.reg_we, bus.pc_we, bus.retire};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic writes_rd(input logic [6:0] o);
        return (o == OP_REG) || (o == OP_IMM) || (o == OP_LUI) ||
               (o == OP_AUIPC) || (o == OP_JAL) || (o == OP_JALR);
    endfunction

    task automatic push(input logic [6:0] o, input logic r, input logic [6:0] s);
        cyc_t c;
        c.op = o; c.rdy = r; c.strobes = s;
        exp_q.push_back(c);
    endtask

    // Expected cycles of one instruction: fw fetch waits, mw memory waits
    task automatic add_instr(input logic [6:0] opc, input int fw, input int mw);
        logic [6:0] s;
        for (int i = 0; i <= fw; i++)
            push(7'($urandom_range(0, 127)), (i == fw), (i == fw) ? (S_REQ | S_IR) : S_REQ);
        push(opc, rnd_bit(), 7'b0);
        if (opc == OP_LOAD || opc == OP_STORE) begin
            push(opc, rnd_bit(), 7'b0);
            for (int i = 0; i <= mw; i++) begin
                s = S_REQ | S_ALU | ((opc == OP_STORE) ? S_WE : 7'b0);
                if (i == mw && opc == OP_STORE) s = s | S_PC | S_RET;
                push(opc, (i == mw), s);
            end
            if (opc == OP_LOAD) push(opc, rnd_bit(), S_REG | S_PC | S_RET);
        end else if (writes_rd(opc)) begin
            push(opc, rnd_bit(), 7'b0);
            push(opc, rnd_bit(), S_REG | S_PC | S_RET);
        end else begin
            push(opc, rnd_bit(), S_PC | S_RET);
        end
    endtask

    task automatic run_trace(input string name);
        cyc_t e;
        int   cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            bus.op = e.op;
            bus.mem_ready = e.rdy;
            #1;
            checks++;
            if (outs() !== e.strobes) begin
                failures++;
                $display("FAIL %s strobes cycle %0d: got %b expected %b", name, cyc, outs(), e.strobes);
            end
            checks++;
            if (bus.instret !== IW'(instret_model) || bus.bus_error !== 1'b0) begin
                failures++;
                $display("FAIL %s instret/bus_error cycle %0d: got %0d/%b expected %0d/0",
                         name, cyc, bus.instret, bus.bus_error, instret_model);
            end
`ifdef ILLEGAL_TRAP_EN
            checks++;
            if (bus.trap !== 1'b0) begin
                failures++;
                $display("FAIL %s trap cycle %0d: got %b expected 0", name, cyc, bus.trap);
            end
`endif
            if (e.strobes[0]) instret_model = (instret_model + 1) % (1 << IW);
            cyc++;
        end
    endtask

    task automatic release_reset(input string name);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs() !== 7'b0 || bus.instret !== IW'(0) || bus.bus_error !== 1'b0) begin
            failures++;
            $display("FAIL %s release: strobes %b instret %0d bus_error %b expected all 0",
                     name, outs(), bus.instret, bus.bus_error);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            bus.mem_ready = rnd_bit();
            bus.op = 7'($urandom_range(0, 127));
            #1;
            checks++;
            if (outs() !== 7'b0 || bus.instret !== IW'(0) || bus.bus_error !== 1'b0) begin
                failures++;
                $display("FAIL reset state: strobes %b instret %0d bus_error %b expected all 0",
                         outs(), bus.instret, bus.bus_error);
            end
        end
        instret_model = 0;
        release_reset("reset");
    endtask

    task automatic test_addi();   add_instr(OP_IMM, 0, 0);    run_trace("addi");   endtask
    task automatic test_load();   add_instr(OP_LOAD, 0, 3);   run_trace("lw_wait3"); endtask
    task automatic test_store();  add_instr(OP_STORE, 0, 0);  run_trace("sw");     endtask
    task automatic test_branch(); add_instr(OP_BRANCH, 0, 0); run_trace("beq");    endtask

    // Four stalled request cycles, then HALT with a late mem_ready, then reset
    task automatic expect_hang(input string name, input logic [6:0] o, input logic [6:0] req_vec);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(posedge clk); #1;
            bus.op = o;
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (outs() !== req_vec || bus.bus_error !== 1'b0) begin
                failures++;
                $display("FAIL %s wait %0d: strobes %b bus_error %b expected %b/0",
                         name, i, outs(), bus.bus_error, req_vec);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.mem_ready = (i == 0) ? 1'b1 : rnd_bit();
            #1;
            checks++;
            if (outs() !== 7'b0 || bus.bus_error !== 1'b1 || bus.instret !== IW'(instret_model)) begin
                failures++;
                $display("FAIL %s halt %0d: strobes %b bus_error %b instret %0d expected 0/1/%0d",
                         name, i, outs(), bus.bus_error, bus.instret, instret_model);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0 || bus.bus_error !== 1'b0 || bus.instret !== IW'(0)) begin
            failures++;
            $display("FAIL %s reset clear: strobes %b bus_error %b instret %0d expected all 0",
                     name, outs(), bus.bus_error, bus.instret);
        end
        instret_model = 0;
        release_reset(name);
    endtask

    task automatic test_timeout_fetch();
        expect_hang("timeout_fetch", 7'($urandom_range(0, 127)), S_REQ);
        add_instr(OP_REG, 1, 0);
        run_trace("restart_after_timeout");
    endtask

    task automatic test_timeout_mem();
        push(7'($urandom_range(0, 127)), 1'b1, S_REQ | S_IR);
        push(OP_STORE, rnd_bit(), 7'b0);
        push(OP_STORE, rnd_bit(), 7'b0);
        run_trace("timeout_mem_prefix");
        expect_hang("timeout_mem", OP_STORE, S_REQ | S_WE | S_ALU);
    endtask

    task automatic test_reset_mid_request();
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_req before reset: mem_req %b expected 1", bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_req reset: mem_req %b expected 0", bus.mem_req);
        end
        instret_model = 0;
        release_reset("mid_req");
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        int before;
        push(7'($urandom_range(0, 127)), 1'b1, S_REQ | S_IR);
        push(OP_BAD, rnd_bit(), 7'b0);
        push(OP_BAD, rnd_bit(), 7'b0);
        run_trace("illegal_prefix");
        before = instret_model;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_ready = rnd_bit();
            #1;
            checks++;
            if (bus.trap !== 1'b1 || outs() !== 7'b0 || bus.instret !== IW'(before)) begin
                failures++;
                $display("FAIL illegal trap: trap %b strobes %b instret %0d expected 1/0/%0d",
                         bus.trap, outs(), bus.instret, before);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.trap !== 1'b0) begin
            failures++;
            $display("FAIL illegal trap reset: trap %b expected 0", bus.trap);
        end
        instret_model = 0;
        release_reset("illegal");
`else
        add_instr(OP_BAD, 1, 0);
        add_instr(7'b0000000, 0, 0);
        run_trace("illegal_nop");
`endif
    endtask

    task automatic test_random();
        logic [6:0] ops [11];
        int n_ops;
        ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_REG, OP_IMM, OP_LUI,
                OP_AUIPC, OP_JAL, OP_JALR, OP_BAD, 7'b1010101};
`ifdef ILLEGAL_TRAP_EN
        n_ops = 9;
`else
        n_ops = 11;
`endif
        for (int n = 0; n < 40; n++)
            add_instr(ops[$urandom_range(0, n_ops - 1)],
                      $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1));
        run_trace("random");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        instret_model = 0;
        rst_n         = 1'b0;
        bus.op        = 7'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_random();
        test_timeout_fetch();
        test_reset_mid_request();
        test_timeout_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
